// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // What happens to the memory word returning this cycle.
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_PUSH,
    RSP_DROP
  } rsp_action_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect, decode handshake.
interface fetch_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  imem_req_valid;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr, pc} pairs with flush; head outputs read NOP/0 when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_instr,
  input  logic [WIDTH-1:0]         push_pc,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_instr,
  output logic [WIDTH-1:0]         head_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             pop_ok;

  always_comb begin
    head_valid = (count != '0);
    full       = (count == (AW+1)'(DEPTH));
    pop_ok     = pop && head_valid;
    head_instr = head_valid ? instr_mem[rd_ptr] : WIDTH'(NOP_INSTR);
    head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= push_instr;
        pc_mem[wr_ptr]    <= push_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop_ok && full));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one request per cycle under
// a credit rule, buffers returned words in fetch_fifo, and flushes on redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(INSTR_BYTES);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'(INSTR_BYTES - 1);

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] tag_pc;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic                  flush;
  logic                  deq;
  logic                  issue;
  logic                  push;
  logic [CW:0]           credit_used;
  rsp_action_t           rsp;

  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [DATA_WIDTH-1:0] head_pc;
  logic                  out_valid;

  // The returning word is pushed in the same cycle it appears; a redirect or
  // reset in that cycle simply drops it, which is the in-flight kill.
  always_comb begin
    flush       = rst || bus.redirect_valid;
    out_valid   = head_valid && !rst;
    deq         = out_valid && bus.instr_ready;
    credit_used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, deq};
    issue       = !flush && (credit_used < (CW+1)'(DEPTH));
    if (!inflight) begin
      rsp = RSP_NONE;
    end else if (flush) begin
      rsp = RSP_DROP;
    end else begin
      rsp = RSP_PUSH;
    end
    push = (rsp == RSP_PUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~ALIGN_MASK;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect_valid),
    .push       (push),
    .push_instr (bus.imem_rdata),
    .push_pc    (tag_pc),
    .pop        (deq),
    .head_valid (head_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (count)
  );

  always_comb begin
    bus.imem_req_valid = issue;
    bus.imem_addr      = fetch_pc;
    bus.instr_valid    = out_valid;
    bus.instr          = out_valid ? head_instr : DATA_WIDTH'(NOP_INSTR);
    bus.instr_pc       = out_valid ? head_pc : '0;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle memory model and an ordered scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_pc;

  fetch_if #(.DATA_WIDTH(32)) bus ();

  fetch_stage #(
    .DATA_WIDTH (32),
    .DEPTH      (2),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory: word at byte address a is a>>2, returned the cycle after the request.
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_req_valid ? (bus.imem_addr >> 2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle once inputs have settled.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid", bus.imem_req_valid, 1'b0);
      chk("rst_instr_valid", bus.instr_valid, 1'b0);
      chk("rst_instr", bus.instr, NOP);
      chk("rst_instr_pc", bus.instr_pc, 32'h0);
      sb.delete();
      model_pc = 32'h0;
    end else begin
      if (!bus.instr_valid) begin
        chk("idle_instr_nop", bus.instr, NOP);
        chk("idle_instr_pc", bus.instr_pc, 32'h0);
      end else if (bus.instr_ready && !bus.redirect_valid) begin
        if (sb.size() == 0) begin
          chk("sb_spurious_deq", bus.instr_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_instr", bus.instr, e.ins);
          chk("sb_instr_pc", bus.instr_pc, e.pc);
        end
      end
      if (bus.redirect_valid) begin
        chk("redirect_no_req", bus.imem_req_valid, 1'b0);
        sb.delete();
        model_pc = {bus.redirect_pc[31:2], 2'b00};
      end else if (bus.imem_req_valid) begin
        chk("sb_req_addr", bus.imem_addr, model_pc);
        sb.push_back('{pc: model_pc, ins: model_pc >> 2});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst                = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    repeat (3) step();
    chk("reset_instr_valid", bus.instr_valid, 1'b0);
    chk("reset_req_valid", bus.imem_req_valid, 1'b0);

    // Reset release: first request to RESET_PC, one word per cycle afterwards.
    rst = 1'b0;
    #1;
    chk("c0_req_valid", bus.imem_req_valid, 1'b1);
    chk("c0_addr", bus.imem_addr, 32'h0);
    step();
    chk("c1_instr_valid", bus.instr_valid, 1'b0);
    chk("c1_addr", bus.imem_addr, 32'h4);
    step();
    chk("c2_instr_valid", bus.instr_valid, 1'b1);
    chk("c2_instr", bus.instr, 32'd0);
    chk("c2_instr_pc", bus.instr_pc, 32'h0);

    // Backpressure: two entries buffered, issue stalls with address held.
    bus.instr_ready = 1'b0;
    #1;
    chk("bp_req_valid", bus.imem_req_valid, 1'b0);
    chk("bp_addr", bus.imem_addr, 32'h8);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_valid", bus.instr_valid, 1'b1);
      chk("bp_hold_instr", bus.instr, 32'd0);
      chk("bp_hold_req", bus.imem_req_valid, 1'b0);
      chk("bp_hold_addr", bus.imem_addr, 32'h8);
    end
    step();
    bus.instr_ready = 1'b1;
    #1;
    chk("rel_req_valid", bus.imem_req_valid, 1'b1);
    chk("rel_addr", bus.imem_addr, 32'h8);
    chk("rel_instr0", bus.instr, 32'd0);
    step();
    chk("rel_instr1", bus.instr, 32'd1);
    chk("rel_pc1", bus.instr_pc, 32'h4);
    step();
    chk("rel_instr2", bus.instr, 32'd2);
    chk("rel_pc2", bus.instr_pc, 32'h8);

    // Sustained throughput.
    for (int i = 3; i <= 5; i++) begin
      step();
      chk("stream_valid", bus.instr_valid, 1'b1);
      chk("stream_instr", bus.instr, 32'(i));
      chk("stream_pc", bus.instr_pc, 32'(4 * i));
    end

    // Redirect with a buffered entry and a response in flight.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    #1;
    chk("redir_req_valid", bus.imem_req_valid, 1'b0);
    step();
    bus.redirect_valid = 1'b0;
    chk("redir_n1_valid", bus.instr_valid, 1'b0);
    chk("redir_n1_instr", bus.instr, NOP);
    #1;
    chk("redir_n1_req", bus.imem_req_valid, 1'b1);
    chk("redir_n1_addr", bus.imem_addr, 32'h40);
    step();
    chk("redir_n2_valid", bus.instr_valid, 1'b0);
    step();
    chk("redir_n3_valid", bus.instr_valid, 1'b1);
    chk("redir_n3_pc", bus.instr_pc, 32'h40);
    chk("redir_n3_instr", bus.instr, 32'h10);

    // Misaligned redirect target is forced to a word boundary.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("align_addr", bus.imem_addr, 32'h40);
    step();
    step();
    chk("align_pc", bus.instr_pc, 32'h40);

    // PC wraps at the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    step();
    chk("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr2", bus.imem_addr, 32'h0);
    chk("wrap_pc0", bus.instr_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc1", bus.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr1", bus.instr, 32'h3FFF_FFFF);
    step();
    chk("wrap_pc2", bus.instr_pc, 32'h0);
    step();
    chk("wrap_pc3", bus.instr_pc, 32'h4);

    // Reset mid-stream with the FIFO non-empty and a response in flight.
    chk("pre_rst_valid", bus.instr_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", bus.instr_valid, 1'b0);
    chk("rst_mid_instr", bus.instr, NOP);
    step();
    rst = 1'b0;
    chk("post_rst_valid", bus.instr_valid, 1'b0);
    chk("post_rst_instr", bus.instr, NOP);
    #1;
    chk("post_rst_req", bus.imem_req_valid, 1'b1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    step();
    step();
    chk("post_rst_first_valid", bus.instr_valid, 1'b1);
    chk("post_rst_first_pc", bus.instr_pc, 32'h0);

    repeat (8) step();
    chk("drain_sb_depth", 32'(sb.size()), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
